// File: rtl/sopc_sysid_checker.sv
// Avalon-MM read master that fetches the SOPC system ID and build timestamp after reset
// and raises a sticky pass/fail verdict, with per-read timeout and bounded retries.
module sopc_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'h0000_0000,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1523842120,
  parameter int          START_DELAY        = 16,
  parameter int          TIMEOUT_CYCLES     = 1024,
  parameter int          MAX_RETRIES        = 3
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        recheck,
  output logic        av_address,
  output logic        av_read,
  input  logic [31:0] av_readdata,
  input  logic        av_waitrequest,
  output logic        busy,
  output logic        sysid_ok,
  output logic        sysid_fail,
  output logic        timed_out,
  output logic [31:0] id_value,
  output logic [31:0] ts_value,
  output logic [3:0]  retry_count
);

  typedef enum logic [2:0] {
    S_DELAY,
    S_RD_ID,
    S_RD_TS,
    S_CHECK,
    S_PASS,
    S_FAIL
  } state_t;

  localparam int DW = (START_DELAY > 1) ? $clog2(START_DELAY) : 1;
  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [DW-1:0] DELAY_LOAD = DW'(START_DELAY - 1);
  localparam logic [TW-1:0] TO_LAST    = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]    RETRY_MAX  = 4'(MAX_RETRIES);

  state_t        state_q, state_d;
  logic [DW-1:0] delay_q, delay_d;
  logic [TW-1:0] to_cnt_q, to_cnt_d;
  logic [3:0]    retry_q, retry_d;
  logic          timed_out_q, timed_out_d;
  logic [31:0]   id_q, id_d;
  logic [31:0]   ts_q, ts_d;
  logic          av_read_q, av_read_d;
  logic          av_address_q, av_address_d;
  logic          attempt_failed;

  always_comb begin
    state_d        = state_q;
    delay_d        = delay_q;
    to_cnt_d       = to_cnt_q;
    retry_d        = retry_q;
    timed_out_d    = timed_out_q;
    id_d           = id_q;
    ts_d           = ts_q;
    attempt_failed = 1'b0;

    case (state_q)
      S_DELAY: begin
        if (delay_q == '0) begin
          state_d  = S_RD_ID;
          to_cnt_d = '0;
        end else begin
          delay_d = delay_q - DW'(1);
        end
      end

      // Acceptance is tested before the timeout limit so it wins a tie.
      S_RD_ID: begin
        if (!av_waitrequest) begin
          id_d        = av_readdata;
          timed_out_d = 1'b0;
          to_cnt_d    = '0;
          state_d     = S_RD_TS;
        end else if (to_cnt_q == TO_LAST) begin
          timed_out_d    = 1'b1;
          attempt_failed = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end

      S_RD_TS: begin
        if (!av_waitrequest) begin
          ts_d        = av_readdata;
          timed_out_d = 1'b0;
          to_cnt_d    = '0;
          state_d     = S_CHECK;
        end else if (to_cnt_q == TO_LAST) begin
          timed_out_d    = 1'b1;
          attempt_failed = 1'b1;
        end else begin
          to_cnt_d = to_cnt_q + TW'(1);
        end
      end

      S_CHECK: begin
        if ((id_q == EXPECTED_ID) && (ts_q == EXPECTED_TIMESTAMP)) begin
          state_d = S_PASS;
        end else begin
          attempt_failed = 1'b1;
        end
      end

      S_PASS, S_FAIL: begin
        if (recheck) begin
          state_d     = S_DELAY;
          delay_d     = DELAY_LOAD;
          retry_d     = '0;
          timed_out_d = 1'b0;
        end
      end

      default: begin
        state_d = S_DELAY;
        delay_d = DELAY_LOAD;
      end
    endcase

    // Mismatch and timeout share one retry/give-up decision.
    if (attempt_failed) begin
      if (retry_q < RETRY_MAX) begin
        retry_d = retry_q + 4'd1;
        state_d = S_DELAY;
        delay_d = DELAY_LOAD;
      end else begin
        state_d = S_FAIL;
      end
    end
  end

  // Strobes are registered from the next state so they line up with the read states.
  always_comb begin
    av_read_d    = (state_d == S_RD_ID) || (state_d == S_RD_TS);
    av_address_d = (state_d == S_RD_TS);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_DELAY;
      delay_q      <= DELAY_LOAD;
      to_cnt_q     <= '0;
      retry_q      <= '0;
      timed_out_q  <= 1'b0;
      id_q         <= '0;
      ts_q         <= '0;
      av_read_q    <= 1'b0;
      av_address_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      delay_q      <= delay_d;
      to_cnt_q     <= to_cnt_d;
      retry_q      <= retry_d;
      timed_out_q  <= timed_out_d;
      id_q         <= id_d;
      ts_q         <= ts_d;
      av_read_q    <= av_read_d;
      av_address_q <= av_address_d;
    end
  end

  assign av_read     = av_read_q;
  assign av_address  = av_address_q;
  assign busy        = (state_q != S_PASS) && (state_q != S_FAIL);
  assign sysid_ok    = (state_q == S_PASS);
  assign sysid_fail  = (state_q == S_FAIL);
  assign timed_out   = timed_out_q;
  assign id_value    = id_q;
  assign ts_value    = ts_q;
  assign retry_count = retry_q;

endmodule

// File: tb/tb_sopc_sysid_checker.sv
// Scoreboard bench for sopc_sysid_checker: a behavioural sysid slave with programmable
// wait states feeds the master; each expected verdict is queued before the run it describes.
module tb_sopc_sysid_checker;

  localparam logic [31:0] EXP_ID = 32'h0000_0000;
  localparam logic [31:0] EXP_TS = 32'd1523842120;
  localparam int SD = 16;
  localparam int TO = 1024;
  localparam int MR = 3;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        recheck = 1'b0;
  logic        av_address;
  logic        av_read;
  logic [31:0] av_readdata = '0;
  logic        av_waitrequest = 1'b0;
  logic        busy;
  logic        sysid_ok;
  logic        sysid_fail;
  logic        timed_out;
  logic [31:0] id_value;
  logic [31:0] ts_value;
  logic [3:0]  retry_count;

  sopc_sysid_checker #(
    .EXPECTED_ID(EXP_ID),
    .EXPECTED_TIMESTAMP(EXP_TS),
    .START_DELAY(SD),
    .TIMEOUT_CYCLES(TO),
    .MAX_RETRIES(MR)
  ) dut (
    .clock(clock),
    .reset_n(reset_n),
    .recheck(recheck),
    .av_address(av_address),
    .av_read(av_read),
    .av_readdata(av_readdata),
    .av_waitrequest(av_waitrequest),
    .busy(busy),
    .sysid_ok(sysid_ok),
    .sysid_fail(sysid_fail),
    .timed_out(timed_out),
    .id_value(id_value),
    .ts_value(ts_value),
    .retry_count(retry_count)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        ok;
    logic        fail;
    logic        to;
    logic [3:0]  retry;
    logic [31:0] id;
    logic [31:0] ts;
    int          lat;
    int          reads;
  } exp_t;

  exp_t sb[$];

  int errs = 0;
  int checks = 0;
  int cyc = 0;
  int cyc0 = 0;
  int rd_cycles = 0;

  // Slave behaviour: wait cycles per read (-1 = stall forever) and returned words.
  int          slave_wait = 0;
  logic [31:0] slave_id = EXP_ID;
  logic [31:0] slave_ts = EXP_TS;
  int          wait_cnt = 0;
  logic        prev_stall = 1'b0;
  logic        prev_addr = 1'b0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      errs++;
      $display("FAIL %s actual=0x%0h required=0x%0h", tag, act, want);
    end
  endtask

  always @(posedge clock) cyc++;

  always @(negedge clock) begin
    if (av_read && prev_stall) chk("addr_stable", {31'd0, av_address}, {31'd0, prev_addr});
    if (av_read) begin
      rd_cycles++;
      if (slave_wait < 0 || wait_cnt < slave_wait) begin
        av_waitrequest = 1'b1;
        wait_cnt++;
      end else begin
        av_waitrequest = 1'b0;
        av_readdata = av_address ? slave_ts : slave_id;
        wait_cnt = 0;
      end
    end else begin
      av_waitrequest = 1'b0;
      wait_cnt = 0;
    end
    prev_stall = av_read && av_waitrequest;
    prev_addr  = av_address;
  end

  task automatic push_exp(input logic ok, input logic fail, input logic to, input int retry,
                          input logic [31:0] id, input logic [31:0] ts, input int lat,
                          input int reads);
    exp_t e;
    e.ok = ok; e.fail = fail; e.to = to; e.retry = 4'(retry);
    e.id = id; e.ts = ts; e.lat = lat; e.reads = reads;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset_n = 1'b0;
    repeat (2) @(negedge clock);
    reset_n = 1'b1;
    cyc0 = cyc;
    rd_cycles = 0;
  endtask

  task automatic wait_verdict(input string tag, input int budget);
    exp_t e;
    int n;
    n = 0;
    while (!(sysid_ok || sysid_fail) && n < budget) begin
      @(negedge clock);
      n++;
    end
    if (sb.size() == 0) begin
      chk({tag, "_sb_empty"}, 32'd0, 32'd1);
      return;
    end
    e = sb.pop_front();
    if (!(sysid_ok || sysid_fail)) begin
      chk({tag, "_verdict_timeout"}, 32'd0, 32'd1);
      return;
    end
    $display("txn %s ok=%0b fail=%0b to=%0b retry=%0d id=0x%0h ts=%0d lat=%0d reads=%0d",
             tag, sysid_ok, sysid_fail, timed_out, retry_count, id_value, ts_value,
             cyc - cyc0, rd_cycles);
    chk({tag, "_ok"},    {31'd0, sysid_ok},   {31'd0, e.ok});
    chk({tag, "_fail"},  {31'd0, sysid_fail}, {31'd0, e.fail});
    chk({tag, "_to"},    {31'd0, timed_out},  {31'd0, e.to});
    chk({tag, "_retry"}, {28'd0, retry_count}, {28'd0, e.retry});
    chk({tag, "_id"},    id_value, e.id);
    chk({tag, "_ts"},    ts_value, e.ts);
    chk({tag, "_lat"},   32'(cyc - cyc0), 32'(e.lat));
    chk({tag, "_reads"}, 32'(rd_cycles), 32'(e.reads));
    chk({tag, "_busy"},  {31'd0, busy}, 32'd0);
  endtask

  initial begin
    int n;

    // Reset values while reset is held
    @(negedge clock);
    reset_n = 1'b0;
    @(negedge clock);
    chk("rst_av_read", {31'd0, av_read}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd1);
    chk("rst_ok", {31'd0, sysid_ok}, 32'd0);
    chk("rst_fail", {31'd0, sysid_fail}, 32'd0);
    chk("rst_retry", {28'd0, retry_count}, 32'd0);
    chk("rst_id", id_value, 32'd0);

    // 1: zero-wait correct slave
    slave_wait = 0; slave_id = EXP_ID; slave_ts = EXP_TS;
    push_exp(1'b1, 1'b0, 1'b0, 0, EXP_ID, EXP_TS, SD + 3, 2);
    do_reset();
    wait_verdict("t1_pass", 200);

    // 2: wrong ID on every read exhausts retries
    slave_id = 32'h1;
    push_exp(1'b0, 1'b1, 1'b0, MR, 32'h1, EXP_TS, (MR + 1) * (SD + 3), 2 * (MR + 1));
    do_reset();
    wait_verdict("t2_mismatch", 500);

    // 5: recheck from FAIL with a correct slave
    slave_id = EXP_ID;
    @(negedge clock);
    recheck = 1'b1;
    @(negedge clock);
    recheck = 1'b0;
    cyc0 = cyc;
    rd_cycles = 0;
    chk("t5_fail_clr", {31'd0, sysid_fail}, 32'd0);
    chk("t5_retry_clr", {28'd0, retry_count}, 32'd0);
    chk("t5_busy", {31'd0, busy}, 32'd1);
    push_exp(1'b1, 1'b0, 1'b0, 0, EXP_ID, EXP_TS, SD + 3, 2);
    wait_verdict("t5_recheck", 200);

    // 3: waitrequest stuck high
    slave_wait = -1;
    push_exp(1'b0, 1'b1, 1'b1, MR, 32'd0, 32'd0, (MR + 1) * (SD + TO), (MR + 1) * TO);
    do_reset();
    wait_verdict("t3_timeout", 6000);

    // 4: five wait states on each read
    slave_wait = 5;
    push_exp(1'b1, 1'b0, 1'b0, 0, EXP_ID, EXP_TS, SD + 13, 12);
    do_reset();
    wait_verdict("t4_wait5", 300);

    // 6: reset during the timestamp read, then a clean pass; a recheck while busy is ignored
    do_reset();
    n = 0;
    while (!(av_read && av_address) && n < 200) begin
      @(negedge clock);
      n++;
    end
    chk("t6_reached_rd_ts", {31'd0, av_read && av_address}, 32'd1);
    #1 reset_n = 1'b0;
    #1;
    chk("t6_rst_av_read", {31'd0, av_read}, 32'd0);
    chk("t6_rst_busy", {31'd0, busy}, 32'd1);
    @(negedge clock);
    reset_n = 1'b1;
    cyc0 = cyc;
    rd_cycles = 0;
    push_exp(1'b1, 1'b0, 1'b0, 0, EXP_ID, EXP_TS, SD + 13, 12);
    repeat (3) @(negedge clock);
    recheck = 1'b1;
    @(negedge clock);
    recheck = 1'b0;
    wait_verdict("t6_after_reset", 300);

    chk("sb_drained", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
